// File: rtl/noc_pkg.sv
// Shared NoC router constants, port indices and scheduler state type.
package noc_pkg;

  localparam int unsigned N_PORTS         = 5;
  localparam int unsigned FLIT_W          = 8;
  localparam int unsigned P_LOCAL         = 0;
  localparam int unsigned P_EAST          = 1;
  localparam int unsigned P_WEST          = 2;
  localparam int unsigned P_NORTH         = 3;
  localparam int unsigned P_SOUTH         = 4;
  localparam int unsigned DEFAULT_CREDITS = 4;

  typedef enum logic [0:0] {
    StIdle,
    StAlloc
  } sched_state_e;

  // Next index in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first requester at or after ptr, wrapping.
module rr_pick
  import noc_pkg::*;
#(
  parameter int unsigned N  = N_PORTS,
  parameter int unsigned PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld
);

  always_comb begin
    int unsigned  idx;
    logic [PW-1:0] pos;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 32'd0;
    pos     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      pos = PW'(idx);
      if (!gnt_vld && req[pos]) begin
        gnt[pos] = 1'b1;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_port_sched.sv
// Per-output-port wormhole scheduler: round-robin packet grant with credit flow control.
// Optional stall watchdog compiled in with ARB_WATCHDOG_EN.
module wormhole_port_sched
  import noc_pkg::*;
#(
  parameter int unsigned N_IN      = N_PORTS,
  parameter int unsigned CREDITS   = DEFAULT_CREDITS,
  parameter int unsigned CW        = 3,
  parameter int unsigned WD_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] vld,
  input  logic [N_IN-1:0] tail,
  input  logic            credit_ret,
  output logic [N_IN-1:0] sel,
  output logic [N_IN-1:0] pop,
  output logic            fire,
  output logic            busy,
  output logic            credit_err,
  output logic            wd_timeout
);

  localparam int unsigned   PW       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] CredFull = CW'(CREDITS);

  sched_state_e  state_q, state_d;
  logic [N_IN-1:0] sel_q, sel_d, gnt;
  logic            gnt_vld;
  logic [PW-1:0]   ptr_q, ptr_d, owner;
  logic [CW-1:0]   credits_q, credits_d;
  logic            credit_err_q, credit_err_d;
  logic            owner_vld, owner_tail, wd_release, release_port;

  rr_pick #(
    .N (N_IN),
    .PW(PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_vld(gnt_vld)
  );

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel_q[i]) owner = PW'(i);
    end
  end

  // sel_q is one-hot while allocated, so masking picks the owner's bit.
  assign owner_vld  = |(sel_q & vld);
  assign owner_tail = |(sel_q & tail);

  // Gated by rst so a flit presented during the reset cycle is never popped.
  assign fire = rst & (state_q == StAlloc) & owner_vld & (credits_q != '0);
  assign pop  = sel_q & {N_IN{fire}};
  assign busy = (state_q == StAlloc);
  assign sel  = sel_q;
  assign credit_err = credit_err_q;

  assign release_port = (fire & owner_tail) | wd_release;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          sel_d   = gnt;
          state_d = StAlloc;
        end
      end
      StAlloc: begin
        if (release_port) begin
          sel_d   = '0;
          state_d = StIdle;
          ptr_d   = PW'(wrap_inc(32'(owner), N_IN));
        end
      end
      default: begin
        sel_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    case ({credit_ret, fire})
      2'b10: begin
        if (credits_q == CredFull) credit_err_d = 1'b1;
        else                       credits_d    = credits_q + CW'(1);
      end
      2'b01:   credits_d = credits_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      ptr_q        <= '0;
      credits_q    <= CredFull;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WD_CYCLES + 1);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;

  // The current stalled cycle counts, so release fires in the WD_CYCLES-th stalled cycle.
  always_comb begin
    wd_cnt_d   = '0;
    wd_release = 1'b0;
    if (rst && (state_q == StAlloc) && !fire) begin
      if (32'(wd_cnt_q) + 32'd1 >= WD_CYCLES) wd_release = 1'b1;
      else                                    wd_cnt_d   = wd_cnt_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) wd_cnt_q <= '0;
    else      wd_cnt_q <= wd_cnt_d;
  end

  assign wd_timeout = wd_release;
`else
  logic unused_wd;
  assign unused_wd  = ^WD_CYCLES;
  assign wd_release = 1'b0;
  assign wd_timeout = 1'b0;
`endif

  a_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(sel_q));
  a_credit_range : assert property (@(posedge clk) disable iff (!rst) credits_q <= CredFull);

endmodule

// File: doc/wormhole_port_sched.md
# wormhole_port_sched

Per-output-port scheduler for the 5-port router crossbar. It arbitrates among the five input FIFOs (local, east, west, north, south) that request one output port. The winner holds the port for a whole packet, and each flit moves only when a downstream credit is available. One instance per output port drives that port's one-hot crossbar select and the per-input FIFO read strobes.

## Interface
Parameters:
- N_IN, 5: number of requesting inputs; index 0 = local, 1 = east, 2 = west, 3 = north, 4 = south.
- CREDITS, 4: downstream buffer depth; also the credit reset value.
- CW, 3: credit counter width; must satisfy 2^CW > CREDITS.
- WD_CYCLES, 64: watchdog limit; used only when the watchdog is compiled in.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- req, in, N_IN: input i has a head flit routed to this port (route-compute enable).
- vld, in, N_IN: input i presents a valid flit this cycle (FIFO non-empty).
- tail, in, N_IN: the flit presented by input i is the packet's tail.
- credit_ret, in, 1: downstream freed one buffer slot (one-cycle pulse).
- sel, out, N_IN: registered one-hot crossbar select; all-zero when idle.
- pop, out, N_IN: FIFO read strobe, pop = sel & {N_IN{fire}}.
- fire, out, 1: a flit crosses the crossbar this cycle.
- busy, out, 1: the port is allocated.
- credit_err, out, 1: sticky flag, set by a credit return while the counter is full.
- wd_timeout, out, 1: one-cycle pulse on a watchdog release (tied 0 when the watchdog is compiled out).

## Operation
- FSM states: IDLE, ALLOC.
- IDLE:
  - If req is nonzero, pick the first requester at or after the rotating pointer ptr, wrapping modulo N_IN.
  - Load sel with the winner's one-hot and go to ALLOC.
  - If req is zero, stay in IDLE with sel = 0.
- ALLOC:
  - fire = vld[owner] & (credits != 0).
  - Each fire decrements credits.
  - A fire with tail[owner] set releases the port: sel goes to 0, the FSM returns to IDLE, and ptr becomes owner+1 mod N_IN.
  - A single-flit packet (head = tail) releases on its only fire.
- Credit counter:
  - +1 on credit_ret, −1 on fire; a simultaneous credit_ret and fire leaves it unchanged.
  - Range 0..CREDITS. A credit_ret at CREDITS with no fire is dropped and sets credit_err.
  - Never decrements below 0, because fire is gated by credits != 0.
- req is ignored in ALLOC; there is no preemption.
- A vld drop mid-packet stalls the port and keeps the grant.

## Timing
- Reset values: state IDLE, sel 0, ptr 0, credits CREDITS, credit_err 0, wd counter 0, wd_timeout 0.
- fire, pop and busy are combinational from registered state plus vld/tail.
- Grant latency: req sampled in IDLE at cycle t produces sel valid and first possible fire at t+1.
- Release: a tail fire at cycle t gives IDLE at t+1 and the next sel at t+2. One bubble between packets is intended.
- Flit throughput is 1 per cycle while credits > 0.
- Reset asserted mid-packet:
  - The next edge forces all reset values, including a credit refill.
  - Any flit presented in that cycle is not popped.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A counter counts ALLOC cycles without a fire and clears on each fire.
  - When it reaches WD_CYCLES, the port is force-released: IDLE, ptr = owner+1, wd_timeout pulses for one cycle.
  - Credits are untouched by a watchdog release.
- ARB_WATCHDOG_EN undefined: no counter, wd_timeout tied 0, and a stalled owner holds the port indefinitely.

## Structure
- Shared noc_pkg holds:
  - N_PORTS = 5
  - FLIT_W = 8
  - port index constants P_LOCAL, P_EAST, P_WEST, P_NORTH, P_SOUTH
  - the state enum for this FSM
  - the default CREDITS value
- Sub-module rr_pick: purely combinational rotating-priority encoder.
  - Inputs req and ptr; outputs a one-hot grant and a grant-valid.
  - Reused by any later VC allocator.

## Test plan
- Round-robin fairness:
  - Stimulus: req=5'b10101 held, 1-flit packets, vld=1, tail=1, credits ample.
  - Required: sel sequence 00001, 00100, 10000, 00001, each with one idle cycle between grants.
- Packet hold:
  - Stimulus: input 1 sends a 4-flit packet while input 3 requests throughout.
  - Required: sel=00010 for 4 fire cycles, then 01000 two cycles after the tail fire.
- Credit exhaustion:
  - Stimulus: CREDITS=4, 6-flit packet, no credit_ret.
  - Required: 4 fires, then stall with fire=0 and sel held.
  - Then a credit_ret pulse gives exactly 1 more fire.
- Credit edge cases:
  - Simultaneous credit_ret and fire at credits=2 leaves credits=2.
  - A credit_ret at credits=4 with no fire sets credit_err and leaves credits at 4.
- Reset mid-packet:
  - Stimulus: rst=0 in the flit-2 cycle of a 5-flit packet.
  - Required: next cycle sel=0, credits=4, ptr=0, pop=0 during reset.
- Watchdog (ARB_WATCHDOG_EN, WD_CYCLES=8):
  - Stimulus: owner 2 with vld=0 after its head flit.
  - Required: wd_timeout pulses 8 cycles after the last fire, sel goes to 0, and the next grant goes to the first requester from index 3.
